fetch_sequencer: RTL

Control FSM that sequences the `program_counter` and instruction fetch for the 16-bit processor. It issues a start-up PC clear, fetches each instruction over a req/ack handshake, and resolves branches, jumps and HALT. It then drives the PC's enable, reset, branch/jump-taken and immediate inputs. It sits between instruction memory, the hazard unit and the PC.

---
 rtl/fetch_seq_pkg.sv | 38 +++
 rtl/fetch_decode.sv | 27 ++
 rtl/fetch_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg
// Shared types and constants for the fetch sequencer and the datapath decoder.
//   state_t        : sequencer FSM states (ST_FLUSH only with FETCH_SEQ_FLUSH_EN)
//   OP_*           : control-flow opcodes in instruction bits [15:12]
//   *_MSB / *_LSB  : opcode and immediate field bounds
//   opcode_of()    : extracts the opcode field from a 16-bit instruction
// Optional feature macro: FETCH_SEQ_FLUSH_EN (adds the FLUSH state).

package fetch_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PC_CLR = 3'd1,
        ST_FETCH  = 3'd2,
        ST_EXEC   = 3'd3,
`ifdef FETCH_SEQ_FLUSH_EN
        ST_FLUSH  = 3'd4,
`endif
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_BEQ  = 4'hC;
    localparam logic [3:0] OP_BNE  = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;
    localparam int BIMM_MSB   = 5;
    localparam int BIMM_LSB   = 0;
    localparam int JIMM_MSB   = 11;
    localparam int JIMM_LSB   = 0;

    function automatic logic [3:0] opcode_of(input logic [15:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_decode.sv
// fetch_decode
// Purely combinational control-flow decode of a 4-bit opcode. Shared with the
// datapath decoder so both sides agree on what counts as a branch/jump/halt.
// Ports:
//   opcode       in  4 : instruction bits [15:12]
//   is_branch_eq out 1 : BEQ
//   is_branch_ne out 1 : BNE
//   is_jump      out 1 : JMP
//   is_halt      out 1 : HALT
// Optional feature macro: none (FETCH_SEQ_FLUSH_EN does not affect decode).

module fetch_decode
    import fetch_seq_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       is_branch_eq,
    output logic       is_branch_ne,
    output logic       is_jump,
    output logic       is_halt
);

    assign is_branch_eq = (opcode == OP_BEQ);
    assign is_branch_ne = (opcode == OP_BNE);
    assign is_jump      = (opcode == OP_JMP);
    assign is_halt      = (opcode == OP_HALT);

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Control FSM sequencing the program counter and instruction fetch of the
// 16-bit processor: start-up PC clear, req/ack instruction fetch with a
// timeout, branch/jump/HALT resolution.
// Ports:
//   clk_pi, reset_pi (async, active-high)
//   start_pi            in  : (re)start from PC 0, honoured in IDLE/HALT only
//   imem_req_po         out : fetch request (registered)
//   imem_ack_pi/instr_pi in : memory response
//   zero_flag_pi, stall_pi in : branch condition and hazard stall (EXEC)
//   pc_clk_en_po, pc_reset_po, branch_taken_po, jump_taken_po out : PC
//       controls, combinational for the PC's next rising edge
//   branch_immediate_po[5:0], jump_immediate_po[11:0] out : from latched instr
//   instr_po[15:0], instr_valid_po out : latched instruction to the datapath
//   halted_po, fetch_err_po (sticky), retired_count_po[15:0] out : status
// Parameter FETCH_TIMEOUT: FETCH cycles without ack before faulting (>=1).
// Optional feature macro: FETCH_SEQ_FLUSH_EN inserts a one-cycle FLUSH state
// after a taken branch or jump.

module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int FETCH_TIMEOUT = 16
) (
    input  logic        clk_pi,
    input  logic        reset_pi,
    input  logic        start_pi,
    output logic        imem_req_po,
    input  logic        imem_ack_pi,
    input  logic [15:0] instr_pi,
    input  logic        zero_flag_pi,
    input  logic        stall_pi,
    output logic        pc_clk_en_po,
    output logic        pc_reset_po,
    output logic        branch_taken_po,
    output logic [5:0]  branch_immediate_po,
    output logic        jump_taken_po,
    output logic [11:0] jump_immediate_po,
    output logic [15:0] instr_po,
    output logic        instr_valid_po,
    output logic        halted_po,
    output logic        fetch_err_po,
    output logic [15:0] retired_count_po
);

    // The wait counter only ever holds 0..FETCH_TIMEOUT-1.
    localparam int WAIT_W = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT);

    state_t             state;
    state_t             next_state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [15:0]        instr_q;
    logic [15:0]        retired_q;
    logic               fetch_err_q;
    logic               req_q;
    logic               valid_q;
    logic               halted_q;

    logic               is_branch_eq;
    logic               is_branch_ne;
    logic               is_jump;
    logic               is_halt;
    logic               fetch_timeout;
    logic               cond_taken;

    fetch_decode u_decode (
        .opcode       (opcode_of(instr_q)),
        .is_branch_eq (is_branch_eq),
        .is_branch_ne (is_branch_ne),
        .is_jump      (is_jump),
        .is_halt      (is_halt)
    );

    // An ack in the last allowed cycle still wins over the timeout.
    assign fetch_timeout = (state == ST_FETCH) && !imem_ack_pi &&
                           (wait_cnt == WAIT_W'(FETCH_TIMEOUT - 1));

    assign cond_taken = (is_branch_eq && zero_flag_pi) ||
                        (is_branch_ne && !zero_flag_pi);

    // State register.
    always_ff @(posedge clk_pi or posedge reset_pi) begin
        if (reset_pi) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus the combinational PC controls.
    always_comb begin
        next_state      = state;
        pc_clk_en_po    = 1'b0;
        pc_reset_po     = 1'b0;
        branch_taken_po = 1'b0;
        jump_taken_po   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_pi) next_state = ST_PC_CLR;
            end
            ST_PC_CLR: begin
                pc_reset_po  = 1'b1;
                pc_clk_en_po = 1'b1;
                next_state   = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack_pi) begin
                    next_state = ST_EXEC;
                end else if (fetch_timeout) begin
                    next_state = ST_HALT;
                end
            end
            ST_EXEC: begin
                if (stall_pi) begin
                    next_state = ST_EXEC;
                end else if (is_halt) begin
                    next_state = ST_HALT;
                end else begin
                    pc_clk_en_po    = 1'b1;
                    branch_taken_po = cond_taken;
                    jump_taken_po   = is_jump;
`ifdef FETCH_SEQ_FLUSH_EN
                    next_state = (cond_taken || is_jump) ? ST_FLUSH : ST_FETCH;
`else
                    next_state = ST_FETCH;
`endif
                end
            end
`ifdef FETCH_SEQ_FLUSH_EN
            ST_FLUSH: begin
                next_state = ST_FETCH;
            end
`endif
            ST_HALT: begin
                if (start_pi) next_state = ST_PC_CLR;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // FETCH wait counter: restarts on every entry into FETCH.
    always_ff @(posedge clk_pi or posedge reset_pi) begin
        if (reset_pi) begin
            wait_cnt <= '0;
        end else if (state == ST_FETCH && next_state == ST_FETCH) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Instruction latch, retired counter and sticky fetch error.
    always_ff @(posedge clk_pi or posedge reset_pi) begin
        if (reset_pi) begin
            instr_q     <= 16'h0000;
            retired_q   <= 16'h0000;
            fetch_err_q <= 1'b0;
        end else begin
            if (state == ST_FETCH && imem_ack_pi) begin
                instr_q <= instr_pi;
            end
            if (state == ST_PC_CLR) begin
                retired_q   <= 16'h0000;
                fetch_err_q <= 1'b0;
            end else begin
                if (state == ST_EXEC && !stall_pi && !is_halt) begin
                    retired_q <= retired_q + 16'd1;
                end
                if (fetch_timeout) begin
                    fetch_err_q <= 1'b1;
                end
            end
        end
    end

    // Status outputs are registered from the upcoming state so they line up
    // with the state they describe and drop immediately on reset.
    always_ff @(posedge clk_pi or posedge reset_pi) begin
        if (reset_pi) begin
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            req_q    <= (next_state == ST_FETCH);
            valid_q  <= (next_state == ST_EXEC);
            halted_q <= (next_state == ST_HALT);
        end
    end

    assign imem_req_po         = req_q;
    assign instr_valid_po      = valid_q;
    assign halted_po           = halted_q;
    assign fetch_err_po        = fetch_err_q;
    assign retired_count_po    = retired_q;
    assign instr_po            = instr_q;
    assign branch_immediate_po = instr_q[BIMM_MSB:BIMM_LSB];
    assign jump_immediate_po   = instr_q[JIMM_MSB:JIMM_LSB];

endmodule
